// File: rtl/pc8001_rom_load_arbiter_if.sv
// CPU-side bus of the shared ROM/RAM port.
// cpu_req is a level held until the one-cycle cpu_ack; cpu_dout is valid only while cpu_ack is high; a cpu_req still high the cycle after cpu_ack is a new request.
interface pc8001_rom_load_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack
    );
endinterface

// File: rtl/pc8001_rom_load_arbiter.sv
// Owns the single BRAM port: ioctl ROM download has priority over CPU accesses,
// and the CPU is held in reset during a load plus a settle window.
module pc8001_rom_load_arbiter #(
    parameter int         ADDR_W     = 15,
    parameter int         ROM_SIZE   = 24576,
    parameter logic [7:0] LOAD_INDEX = 8'd1,
    parameter int         HOLD_CYC   = 16
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ioctl_download,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_wr,
    input  logic [24:0]           ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    pc8001_rom_load_arbiter_if.slave cpu,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    input  logic [7:0]            mem_rdata,
    output logic                  cpu_reset_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [1:0]            fsm_state
);
    localparam int                CNT_W     = $clog2(HOLD_CYC + 1);
    localparam logic [ADDR_W-1:0] ROM_LIMIT = ADDR_W'(ROM_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic               hold_nxt, done_nxt, err_nxt;
    logic               pend_wr, busy, ack_pipe;
    logic               start, cap, oob, grant;

    assign start = ioctl_download && (ioctl_index == LOAD_INDEX);
    assign cap   = (state == LOAD) && ioctl_wr && (ioctl_addr[24:ADDR_W] == '0);
    assign oob   = (state == LOAD) && ioctl_wr && (ioctl_addr[24:ADDR_W] != '0);
    assign grant = !cap && cpu.cpu_req && !busy;

    assign fsm_state    = state;
    assign cpu.cpu_dout = cpu.cpu_ack ? mem_rdata : 8'h00;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state          <= IDLE;
            hold_cnt       <= '0;
            cpu_reset_hold <= 1'b0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
        end else begin
            state          <= state_nxt;
            hold_cnt       <= hold_cnt_nxt;
            cpu_reset_hold <= hold_nxt;
            load_done      <= done_nxt;
            load_err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        hold_nxt     = cpu_reset_hold;
        done_nxt     = load_done;
        err_nxt      = load_err || oob || (cap && pend_wr);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    hold_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            LOAD: begin
                if (!ioctl_download) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = CNT_W'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (start) begin
                    state_nxt = LOAD;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                end else if (hold_cnt == '0) begin
                    state_nxt = IDLE;
                    hold_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Loader bytes go straight into the port registers; pend_wr marks a loader
    // write in flight so a strobe in the very next cycle is flagged as an overrun.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
            mem_we      <= 1'b0;
            pend_wr     <= 1'b0;
            busy        <= 1'b0;
            ack_pipe    <= 1'b0;
            cpu.cpu_ack <= 1'b0;
        end else begin
            pend_wr     <= cap;
            ack_pipe    <= grant;
            cpu.cpu_ack <= ack_pipe;
            if (cap) begin
                mem_addr  <= ioctl_addr[ADDR_W-1:0];
                mem_wdata <= ioctl_dout;
                mem_we    <= 1'b1;
            end else if (grant) begin
                mem_addr  <= cpu.cpu_addr;
                mem_wdata <= cpu.cpu_din;
                mem_we    <= cpu.cpu_we && (cpu.cpu_addr >= ROM_LIMIT);
            end else begin
                mem_we    <= 1'b0;
            end
            if (grant) begin
                busy <= 1'b1;
            end else if (cpu.cpu_ack) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pc8001_rom_load_arbiter.sv
// Bench for pc8001_rom_load_arbiter: download/hold sequencing, CPU access table,
// loader/CPU collision, overflow, reset mid-load, and randomized CPU traffic.
module tb_pc8001_rom_load_arbiter;
    localparam int ADDR_W   = 15;
    localparam int ROM_SIZE = 24576;
    localparam int HOLD_CYC = 16;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata = 8'h00;
    logic              cpu_reset_hold;
    logic              load_done;
    logic              load_err;
    logic [1:0]        fsm_state;

    pc8001_rom_load_arbiter_if #(.ADDR_W(ADDR_W)) cpu_bus();

    pc8001_rom_load_arbiter dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .cpu            (cpu_bus),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_rdata      (mem_rdata),
        .cpu_reset_hold (cpu_reset_hold),
        .load_done      (load_done),
        .load_err       (load_err),
        .fsm_state      (fsm_state)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] init_pat(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    // BRAM with one-cycle registered read; unwritten locations hold init_pat.
    logic [7:0] ram[int];
    always @(posedge clk_sys) begin
        mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : init_pat(int'(mem_addr));
        if (mem_we) ram[int'(mem_addr)] = mem_wdata;
    end

    logic [22:0] we_log[$];
    int          hold_hi = 0;
    always @(negedge clk_sys) begin
        if (!reset && mem_we) we_log.push_back({mem_addr, mem_wdata});
        if (cpu_reset_hold) hold_hi++;
    end

    // Reference image of what the BRAM should contain.
    logic [7:0] ref_mem[int];
    function automatic logic [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
    endfunction

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        step();
    endtask

    task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        step();
        ioctl_wr = 1'b0;
        step();
    endtask

    task automatic wait_hold_release(output int n);
        ioctl_download = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!cpu_reset_hold) break;
            n++;
        end
    endtask

    task automatic cpu_access(input logic we, input logic [14:0] a, input logic [7:0] din,
                              output logic [7:0] dout, output int lat, output logic we_seen);
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_we   = we;
        cpu_bus.cpu_addr = a;
        cpu_bus.cpu_din  = din;
        lat = 0;
        we_seen = 1'b0;
        dout = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (mem_we) we_seen = 1'b1;
            if (cpu_bus.cpu_ack) begin
                dout = cpu_bus.cpu_dout;
                break;
            end
        end
        cpu_bus.cpu_req = 1'b0;
        cpu_bus.cpu_we  = 1'b0;
        step();
        check("ack_single_cycle", cpu_bus.cpu_ack, 1'b0);
    endtask

    task automatic ref_cpu(input logic we, input logic [14:0] a, input logic [7:0] d);
        if (we && int'(a) >= ROM_SIZE) ref_mem[int'(a)] = d;
    endtask

    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp_dout;
        logic        exp_we;
    } cpu_vec_t;

    localparam int NV = 12;
    cpu_vec_t vecs[NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, lat, we_base, hold_base;
        logic [7:0]  d;
        logic        ws;
        logic        rw;
        logic [14:0] ra;
        logic [7:0]  rd;

        vecs[0]  = '{1'b0, 15'h0002, 8'h00, 8'hA2, 1'b0};
        vecs[1]  = '{1'b1, 15'h0010, 8'h55, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 15'h0010, 8'h00, 8'h4A, 1'b0};
        vecs[3]  = '{1'b1, 15'h7000, 8'h55, 8'h00, 1'b1};
        vecs[4]  = '{1'b0, 15'h7000, 8'h00, 8'h55, 1'b0};
        vecs[5]  = '{1'b1, 15'h5FFF, 8'hAA, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 15'h5FFF, 8'h00, 8'hA5, 1'b0};
        vecs[7]  = '{1'b1, 15'h6000, 8'hC3, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 15'h6000, 8'h00, 8'hC3, 1'b0};
        vecs[9]  = '{1'b0, 15'h0000, 8'h00, 8'hA0, 1'b0};
        vecs[10] = '{1'b0, 15'h0003, 8'h00, 8'hA3, 1'b0};
        vecs[11] = '{1'b0, 15'h0004, 8'h00, 8'h5E, 1'b0};

        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = 8'h00;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = 8'h00;
        cpu_bus.cpu_req = 1'b0;
        cpu_bus.cpu_we = 1'b0;
        cpu_bus.cpu_addr = '0;
        cpu_bus.cpu_din = 8'h00;
        repeat (3) step();
        check("rst_ack", cpu_bus.cpu_ack, 1'b0);
        check("rst_dout", cpu_bus.cpu_dout, 8'h00);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 15'h0);
        check("rst_hold", cpu_reset_hold, 1'b0);
        check("rst_done", load_done, 1'b0);
        check("rst_err", load_err, 1'b0);
        check("rst_state", fsm_state, 2'd0);
        reset = 1'b0;
        step();

        // Four-byte image, then the settle window.
        we_base = we_log.size();
        start_dl(8'd1);
        check("t1_hold_rise", cpu_reset_hold, 1'b1);
        for (int i = 0; i < 4; i++) begin
            write_byte(25'(i), 8'(8'hA0 + i));
            ref_mem[i] = 8'(8'hA0 + i);
        end
        wait_hold_release(n);
        check("t1_hold_cycles", n, HOLD_CYC);
        check("t1_we_count", we_log.size() - we_base, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t1_we%0d", i), we_log[we_base + i], {15'(i), 8'(8'hA0 + i)});
        check("t1_done", load_done, 1'b1);
        check("t1_err", load_err, 1'b0);
        check("t1_state_idle", fsm_state, 2'd0);

        for (int k = 0; k < NV; k++) begin
            cpu_access(vecs[k].we, vecs[k].addr, vecs[k].din, d, lat, ws);
            ref_cpu(vecs[k].we, vecs[k].addr, vecs[k].din);
            check($sformatf("vec%0d_lat", k), lat, 2);
            check($sformatf("vec%0d_we", k), ws, vecs[k].exp_we);
            if (!vecs[k].we) check($sformatf("vec%0d_rd", k), d, vecs[k].exp_dout);
        end

        // Loader strobe and CPU request in the same cycle.
        start_dl(8'd1);
        ioctl_wr = 1'b1;
        ioctl_addr = 25'h100;
        ioctl_dout = 8'h77;
        cpu_bus.cpu_req = 1'b1;
        cpu_bus.cpu_we = 1'b0;
        cpu_bus.cpu_addr = 15'h0001;
        ref_mem[32'h100] = 8'h77;
        step();
        check("t4_ld_we", mem_we, 1'b1);
        check("t4_ld_addr", mem_addr, 15'h100);
        check("t4_ld_data", mem_wdata, 8'h77);
        ioctl_wr = 1'b0;
        step();
        check("t4_cpu_addr", mem_addr, 15'h0001);
        check("t4_cpu_we", mem_we, 1'b0);
        check("t4_ack_early", cpu_bus.cpu_ack, 1'b0);
        step();
        check("t4_ack", cpu_bus.cpu_ack, 1'b1);
        check("t4_dout", cpu_bus.cpu_dout, 8'hA1);
        cpu_bus.cpu_req = 1'b0;
        step();
        check("t4_ack_low", cpu_bus.cpu_ack, 1'b0);
        wait_hold_release(n);
        check("t4_done", load_done, 1'b1);
        check("t4_err", load_err, 1'b0);

        // Byte past the end of the BRAM, plus the last valid address.
        we_base = we_log.size();
        start_dl(8'd1);
        check("t5_done_clear", load_done, 1'b0);
        write_byte(25'h8000, 8'hEE);
        write_byte(25'h7FFF, 8'h5C);
        ref_mem[32'h7FFF] = 8'h5C;
        write_byte(25'h0020, 8'h33);
        ref_mem[32'h20] = 8'h33;
        wait_hold_release(n);
        check("t5_hold_cycles", n, HOLD_CYC);
        check("t5_we_count", we_log.size() - we_base, 2);
        check("t5_we0", we_log[we_base], {15'h7FFF, 8'h5C});
        check("t5_err", load_err, 1'b1);
        check("t5_done", load_done, 1'b1);

        // Reset mid-load, then a download for another file index.
        start_dl(8'd1);
        write_byte(25'h0040, 8'h99);
        ref_mem[32'h40] = 8'h99;
        reset = 1'b1;
        ioctl_download = 1'b0;
        step();
        check("t6_hold", cpu_reset_hold, 1'b0);
        check("t6_done", load_done, 1'b0);
        check("t6_err", load_err, 1'b0);
        check("t6_state", fsm_state, 2'd0);
        reset = 1'b0;
        step();
        we_base = we_log.size();
        hold_base = hold_hi;
        start_dl(8'd2);
        write_byte(25'h0050, 8'h11);
        write_byte(25'h0051, 8'h22);
        ioctl_download = 1'b0;
        repeat (4) step();
        check("t6_we_count", we_log.size() - we_base, 0);
        check("t6_hold_cycles", hold_hi - hold_base, 0);
        check("t6_state_idle", fsm_state, 2'd0);
        check("t6_done_idx2", load_done, 1'b0);

        // Randomized CPU traffic against the reference image.
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 3))
                0: ra = 15'($urandom_range(0, 32'h7F));
                1: ra = 15'(32'h5FF0 + $urandom_range(0, 32'h1F));
                2: ra = 15'(32'h7000 + $urandom_range(0, 32'hF));
                default: ra = 15'($urandom_range(0, 32'h7FFF));
            endcase
            rw = 1'($urandom_range(0, 1));
            rd = 8'($urandom_range(0, 255));
            if (!rw) exp_q.push_back(ref_rd(int'(ra)));
            cpu_access(rw, ra, rd, d, lat, ws);
            check("rnd_lat", lat, 2);
            if (rw) begin
                check("rnd_we", ws, int'(ra) >= ROM_SIZE);
                ref_cpu(rw, ra, rd);
            end else begin
                check("rnd_rd", d, exp_q.pop_front());
            end
            repeat ($urandom_range(0, 2)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
